// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC sequencer.
// Optional build macro used by mac_sequencer: MAC_SEQUENCER_PERF_EN.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    RESULT
  } mac_seq_state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int LEN_WIDTH_DEF  = 8;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/processing_element.sv
// Multiply-accumulate processing element driven by mac_sequencer.
// The accumulator plus an output pipeline give LATENCY cycles from input beat to result.
module processing_element #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] weight,
  input  logic                  valid,
  input  logic                  accumulate_en,
  input  logic                  clear_acc,
  input  logic                  use_partial_sum,
  input  logic [ACC_WIDTH-1:0]  partial_sum,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam int PIPE = LATENCY - 1;

  logic [2*DATA_WIDTH-1:0] product;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [ACC_WIDTH-1:0]    pipe_q [PIPE];

  assign product = (2*DATA_WIDTH)'(data) * (2*DATA_WIDTH)'(weight);

  // The partial sum is folded in at the first pipeline stage, not into the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
    end else begin
      if (clear_acc) begin
        acc_q <= '0;
      end else if (valid && accumulate_en) begin
        acc_q <= acc_q + ACC_WIDTH'(product);
      end
      pipe_q[0] <= acc_q + (use_partial_sum ? partial_sum : '0);
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result = pipe_q[PIPE-1];

endmodule

// File: rtl/mac_sequencer.sv
// Job sequencer feeding an external MAC processing element and returning its result.
// Define MAC_SEQUENCER_PERF_EN to add the perf_cycles / perf_stalls counters.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int PE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  k_len,
  input  logic                  use_psum,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] in_weight,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic [DATA_WIDTH-1:0] pe_weight,
  output logic                  pe_valid,
  output logic                  pe_accumulate_en,
  output logic                  pe_clear_acc,
  output logic                  pe_use_partial_sum,
  output logic [ACC_WIDTH-1:0]  pe_partial_sum,
  input  logic [ACC_WIDTH-1:0]  pe_result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ACC_WIDTH-1:0]  result_data,
  output logic                  busy,
  output logic                  done
`ifdef MAC_SEQUENCER_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
`endif
);

  localparam int DCW = $clog2(PE_LATENCY + 1);
  localparam logic [DCW-1:0]       DRAIN_LAST = DCW'(PE_LATENCY - 1);
  localparam logic [DCW-1:0]       DRAIN_ONE  = 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = 1;

  mac_seq_state_t       state_q, state_d;
  logic [LEN_WIDTH-1:0] k_len_q;
  logic [LEN_WIDTH-1:0] beat_cnt_q;
  logic [DCW-1:0]       drain_cnt_q;
  logic                 use_psum_q;
  logic [ACC_WIDTH-1:0] psum_q;
  logic [ACC_WIDTH-1:0] result_q;
  logic                 in_stream;

  // Next-state and per-state PE control.
  always_comb begin
    state_d          = state_q;
    in_ready         = 1'b0;
    pe_valid         = 1'b0;
    pe_clear_acc     = 1'b0;
    pe_accumulate_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        pe_clear_acc = 1'b1;
        state_d      = (k_len_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        in_ready         = 1'b1;
        pe_accumulate_en = 1'b1;
        pe_valid         = in_valid;
        // Comparing against k_len-1 before incrementing keeps k_len=all-ones wrap-free.
        if (in_valid && (beat_cnt_q == k_len_q - LEN_ONE)) state_d = DRAIN;
      end
      DRAIN: begin
        pe_accumulate_en = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) state_d = RESULT;
      end
      RESULT: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      use_psum_q  <= 1'b0;
      psum_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          beat_cnt_q  <= '0;
          drain_cnt_q <= '0;
          if (start) begin
            k_len_q    <= k_len;
            use_psum_q <= use_psum;
            psum_q     <= psum_in;
          end
        end
        STREAM: begin
          if (in_valid) beat_cnt_q <= beat_cnt_q + LEN_ONE;
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
          if (drain_cnt_q == DRAIN_LAST) result_q <= pe_result;
        end
        default: ;
      endcase
    end
  end

  assign in_stream          = (state_q == STREAM);
  assign busy               = (state_q != IDLE);
  assign result_valid       = (state_q == RESULT);
  assign result_data        = result_q;
  assign done               = result_valid && result_ready;
  assign pe_data            = in_stream ? in_data : '0;
  assign pe_weight          = in_stream ? in_weight : '0;
  assign pe_use_partial_sum = busy && use_psum_q;
  assign pe_partial_sum     = busy ? psum_q : '0;

`ifdef MAC_SEQUENCER_PERF_EN
  logic [31:0] cycles_run_q;
  logic [31:0] stalls_run_q;

  // Running counts restart in IDLE and are published on the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_run_q <= '0;
      stalls_run_q <= '0;
      perf_cycles  <= '0;
      perf_stalls  <= '0;
    end else begin
      if (!busy) begin
        cycles_run_q <= '0;
        stalls_run_q <= '0;
      end else begin
        cycles_run_q <= sat_inc(cycles_run_q);
        if (in_stream && !in_valid) stalls_run_q <= sat_inc(stalls_run_q);
      end
      if (done) begin
        perf_cycles <= sat_inc(cycles_run_q);
        perf_stalls <= stalls_run_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer paired with processing_element.
// Expected results come from a plain sum-of-products model of each job.
module tb_mac_sequencer;
  import mac_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int AW = ACC_WIDTH_DEF;
  localparam int LW = LEN_WIDTH_DEF;
  localparam int PL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] k_len = '0;
  logic          use_psum = 1'b0;
  logic [AW-1:0] psum_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_weight = '0;
  logic [DW-1:0] pe_data, pe_weight;
  logic          pe_valid, pe_accumulate_en, pe_clear_acc, pe_use_partial_sum;
  logic [AW-1:0] pe_partial_sum, pe_result;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [AW-1:0] result_data;
  logic          busy, done;
`ifdef MAC_SEQUENCER_PERF_EN
  logic [31:0]   perf_cycles, perf_stalls;
`endif

  int            checks = 0;
  int            errors = 0;
  int            pe_beats = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] op_d[256];
  logic [DW-1:0] op_w[256];

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW), .PE_LATENCY(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .use_psum(use_psum),
    .psum_in(psum_in), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .pe_data(pe_data), .pe_weight(pe_weight), .pe_valid(pe_valid),
    .pe_accumulate_en(pe_accumulate_en), .pe_clear_acc(pe_clear_acc),
    .pe_use_partial_sum(pe_use_partial_sum), .pe_partial_sum(pe_partial_sum),
    .pe_result(pe_result), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .busy(busy), .done(done)
`ifdef MAC_SEQUENCER_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  processing_element #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LATENCY(PL)) u_pe (
    .clk(clk), .rst_n(rst_n), .data(pe_data), .weight(pe_weight), .valid(pe_valid),
    .accumulate_en(pe_accumulate_en), .clear_acc(pe_clear_acc),
    .use_partial_sum(pe_use_partial_sum), .partial_sum(pe_partial_sum), .result(pe_result)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A job's answer is just the dot product of its operands plus the optional partial sum.
  function automatic logic [AW-1:0] model(input int klen, input bit up, input logic [AW-1:0] ps);
    logic [AW-1:0] sum = up ? ps : '0;
    for (int i = 0; i < klen; i++) sum += AW'(op_d[i]) * AW'(op_w[i]);
    return sum;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_result_valid"}, result_valid, 0);
    checkOutput({tag, "_result_data"}, result_data, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pe_valid"}, pe_valid, 0);
    checkOutput({tag, "_pe_data"}, {pe_data, pe_weight}, 0);
    checkOutput({tag, "_pe_ctrl"}, {pe_accumulate_en, pe_clear_acc, pe_use_partial_sum}, 0);
    checkOutput({tag, "_pe_partial_sum"}, pe_partial_sum, 0);
  endtask

  // gap < 0 picks random bubbles per beat; abort_after >= 0 resets mid-stream instead of finishing.
  task automatic applyStimulus(input int klen, input bit up, input logic [AW-1:0] ps,
                               input int gap, input int hold, input int abort_after);
    int g;
    int t;
    pe_beats = 0;
    if (abort_after < 0) exp_q.push_back(model(klen, up, ps));
    start = 1'b1; k_len = LW'(klen); use_psum = up; psum_in = ps;
    step();
    start = 1'b0;
    for (int i = 0; i < klen; i++) begin
      if (i == abort_after) begin
        in_valid = 1'b1; in_data = 8'hAA; in_weight = 8'h55;
        #3 rst_n = 1'b0;
        #1 checkResetOutputs("midjob_reset");
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        return;
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      in_valid = 1'b0;
      repeat (g) step();
      in_valid = 1'b1; in_data = op_d[i]; in_weight = op_w[i];
      t = 0;
      while (!in_ready && t < 50) begin step(); t++; end
      if (t >= 50) begin
        checkOutput("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
    t = 1;
    while (!result_valid && t <= 2000) begin step(); t++; end
    if (t > 2000) begin
      checkOutput("result_timeout", 0, 1);
      return;
    end
    if (klen > 0) checkOutput("latency", t, PL + 1);
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0; start = 1'b1; k_len = LW'($urandom);
      step();
    end
    result_ready = 1'b1; start = 1'b1;
    step();
    result_ready = 1'b0; start = 1'b0;
    checkOutput("idle_after_handshake", busy, 0);
    checkOutput("done_single_cycle", done, 0);
    checkOutput("pe_beats", pe_beats, klen);
  endtask

  // Monitor: checks held results against the scoreboard head and pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_valid) begin
        pe_beats++;
        checkOutput("pe_operands", {pe_data, pe_weight}, {in_data, in_weight});
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", result_data, 0);
        end else begin
          checkOutput("result_data", result_data, exp_q[0]);
          if (result_ready) begin
            checkOutput("done_at_handshake", done, 1);
            void'(exp_q.pop_front());
          end else begin
            checkOutput("done_before_handshake", done, 0);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12 checkResetOutputs("power_on_reset");
    @(posedge clk);
    #4 rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin op_d[i] = DW'(2*i + 1); op_w[i] = DW'(2*i + 2); end
    applyStimulus(4, 1'b0, 32'd0, 0, 5, -1);

    for (int i = 0; i < 3; i++) begin op_d[i] = 8'd2; op_w[i] = 8'd3; end
    applyStimulus(3, 1'b1, 32'd10, 2, 0, -1);

    applyStimulus(0, 1'b1, 32'd7, 0, 1, -1);

    for (int i = 0; i < 4; i++) begin op_d[i] = DW'(i + 3); op_w[i] = DW'(i + 4); end
    applyStimulus(4, 1'b1, 32'd5, 0, 0, 2);
    op_d[0] = 8'd9; op_w[0] = 8'd9;
    applyStimulus(1, 1'b0, 32'd0, 0, 0, -1);

    for (int i = 0; i < 255; i++) begin op_d[i] = 8'd255; op_w[i] = 8'd255; end
    applyStimulus(255, 1'b0, 32'd0, 0, 0, -1);
    applyStimulus(255, 1'b0, 32'd0, 0, 0, -1);

    for (int j = 0; j < 8; j++) begin
      int kl;
      kl = int'($urandom_range(0, 12));
      for (int i = 0; i < kl; i++) begin op_d[i] = DW'($urandom); op_w[i] = DW'($urandom); end
      applyStimulus(kl, 1'($urandom), AW'($urandom), -1, int'($urandom_range(0, 3)), -1);
    end

    repeat (2) step();
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
